muldiv_seq: RTL and testbench

Sequencer for the shared multiply/divide resource and the HI/LO register pair. On a single-cycle start request from the main control unit, it drives the MULT or DIV unit for a fixed number of cycles and steers the HI/LO input muxes. It then writes HI/LO once and reports completion, or aborts and raises an exception request on divide-by-zero. It sits between the control FSM and the MULT/DIV units, the HI_mux/LO_mux and the HI/LO registers.

---
 rtl/muldiv_seq.sv | 110 +++++++++++
 tb/tb_muldiv_seq.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// muldiv_seq: sequencer for the shared MULT/DIV unit and the HI/LO register pair.
// After an accepted start, it enables the selected unit for a fixed number of cycles.
// It then writes HI/LO once and pulses done.
// On divide-by-zero it aborts instead and raises exc_div0.
module muldiv_seq #(
    parameter int MULT_CYCLES = 32,
    parameter int DIV_CYCLES  = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] op,
    input  logic       div_zero,
    output logic       MULT_ctrl,
    output logic       DIV_ctrl,
    output logic       DIV_type,
    output logic       HI_ctrl,
    output logic       LO_ctrl,
    output logic       HILO_write,
    output logic       busy,
    output logic       done,
    output logic       exc_div0
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    // A one-cycle unit still needs a one-bit counter.
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_ABORT = 2'd3;

    localparam logic [1:0] OP_MULT = 2'b00;
    localparam logic [1:0] OP_DIVM = 2'b10;
    localparam logic [1:0] OP_RSVD = 2'b11;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          is_div_q, is_div_d;
    logic          hilo_sel_q, hilo_sel_d;
    logic          div_type_q, div_type_d;

    // Next-state logic.
    // Mux selects only change when a start is accepted, so the HI/LO path stays stable.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        is_div_d   = is_div_q;
        hilo_sel_d = hilo_sel_q;
        div_type_d = div_type_q;
        case (state_q)
            S_IDLE: begin
                if (start && (op != OP_RSVD)) begin
                    state_d    = S_RUN;
                    is_div_d   = (op != OP_MULT);
                    hilo_sel_d = (op == OP_MULT);
                    div_type_d = (op == OP_DIVM);
                    cnt_d      = (op == OP_MULT) ? MULT_LOAD : DIV_LOAD;
                end
            end
            S_RUN: begin
                // A divide-by-zero wins even on the last RUN cycle.
                if (is_div_q && div_zero) begin
                    state_d = S_ABORT;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = S_WRITE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_WRITE: state_d = S_IDLE;
            S_ABORT: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and configuration registers, asynchronously cleared.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            is_div_q   <= 1'b0;
            hilo_sel_q <= 1'b0;
            div_type_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_div_q   <= is_div_d;
            hilo_sel_q <= hilo_sel_d;
            div_type_q <= div_type_d;
        end
    end

    // Outputs decode only registered state, so no input reaches an output combinationally.
    assign MULT_ctrl  = (state_q == S_RUN) && !is_div_q;
    assign DIV_ctrl   = (state_q == S_RUN) &&  is_div_q;
    assign DIV_type   = div_type_q;
    assign HI_ctrl    = hilo_sel_q;
    assign LO_ctrl    = hilo_sel_q;
    assign HILO_write = (state_q == S_WRITE);
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_WRITE) || (state_q == S_ABORT);
    assign exc_div0   = (state_q == S_ABORT);

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: scenario-driven bench for muldiv_seq.
// dut1 uses the default cycle counts; dut2 uses MULT_CYCLES=1 and DIV_CYCLES=4.
module tb_muldiv_seq;

    typedef struct packed {
        logic [7:0] en;        // cycles with the selected unit enabled
        logic [7:0] oth;       // cycles with the other unit enabled
        logic [7:0] busy;
        logic [7:0] hilo;
        logic [7:0] done;
        logic [7:0] exc;
        logic [7:0] done_at;   // operation cycle index of done
        logic       hilo_at_done;
        logic       exc_at_done;
        logic [1:0] hisel;     // {HI_ctrl, LO_ctrl} at done
        logic       dtype;
        logic [1:0] hisel_after;
        logic       dtype_after;
        logic [5:0] idle_rest; // enables and strobes in the first idle cycle
        logic       tmo;
    } obs_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start_v, dz_v, sel;
    logic [1:0] op_v;
    logic       start1, start2, dz1, dz2;
    logic       m1, dv1, dt1, hi1, lo1, hw1, b1, dn1, ex1;
    logic       m2, dv2, dt2, hi2, lo2, hw2, b2, dn2, ex2;
    logic [8:0] o1, o2;

    int   tests = 0;
    int   fails = 0;
    obs_t exp_q[$];

    assign start1 = start_v & ~sel;
    assign start2 = start_v &  sel;
    assign dz1    = dz_v & ~sel;
    assign dz2    = dz_v &  sel;
    assign o1 = {m1, dv1, dt1, hi1, lo1, hw1, b1, dn1, ex1};
    assign o2 = {m2, dv2, dt2, hi2, lo2, hw2, b2, dn2, ex2};

    muldiv_seq dut1 (
        .clk(clk), .reset(rst_n), .start(start1), .op(op_v), .div_zero(dz1),
        .MULT_ctrl(m1), .DIV_ctrl(dv1), .DIV_type(dt1), .HI_ctrl(hi1), .LO_ctrl(lo1),
        .HILO_write(hw1), .busy(b1), .done(dn1), .exc_div0(ex1)
    );

    muldiv_seq #(.MULT_CYCLES(1), .DIV_CYCLES(4)) dut2 (
        .clk(clk), .reset(rst_n), .start(start2), .op(op_v), .div_zero(dz2),
        .MULT_ctrl(m2), .DIV_ctrl(dv2), .DIV_type(dt2), .HI_ctrl(hi2), .LO_ctrl(lo2),
        .HILO_write(hw2), .busy(b2), .done(dn2), .exc_div0(ex2)
    );

    function automatic obs_t exp_ok(input int n, input bit m, input bit d);
        obs_t e = '0;
        e.en = 8'(n); e.busy = 8'(n + 1); e.hilo = 8'd1; e.done = 8'd1;
        e.done_at = 8'(n + 1); e.hilo_at_done = 1'b1;
        e.hisel = {m, m}; e.dtype = d; e.hisel_after = {m, m}; e.dtype_after = d;
        return e;
    endfunction

    function automatic obs_t exp_abort(input int k, input bit d);
        obs_t e = '0;
        e.en = 8'(k); e.busy = 8'(k + 1); e.done = 8'd1; e.exc = 8'd1;
        e.done_at = 8'(k + 1); e.exc_at_done = 1'b1;
        e.dtype = d; e.dtype_after = d;
        return e;
    endfunction

    function automatic string fmt(input obs_t r);
        return $sformatf("en=%0d oth=%0d busy=%0d hilo=%0d done=%0d exc=%0d at=%0d hd=%b ed=%b hl=%b dt=%b hla=%b dta=%b idle=%b tmo=%b",
                         r.en, r.oth, r.busy, r.hilo, r.done, r.exc, r.done_at, r.hilo_at_done,
                         r.exc_at_done, r.hisel, r.dtype, r.hisel_after, r.dtype_after, r.idle_rest, r.tmo);
    endfunction

    // Issue (or continue) one operation on the selected DUT and record what it did.
    task automatic run_op(input bit s, input logic [1:0] o, input int dz_cyc,
                          input bit hold, input bit already, output obs_t r);
        logic [8:0] ov;
        bit         ended = 0;
        sel = s;
        if (!already) begin
            @(negedge clk);
            op_v = o; start_v = 1'b1;
        end
        @(posedge clk);
        r = '0;
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk);
            ov = s ? o2 : o1;
            if (!ov[2]) begin
                r.hisel_after = ov[5:4];
                r.dtype_after = ov[6];
                r.idle_rest   = {ov[8:7], ov[3:0]};
                ended = 1;
                break;
            end
            r.en   = r.en   + 8'((o == 2'b00) ? ov[8] : ov[7]);
            r.oth  = r.oth  + 8'((o == 2'b00) ? ov[7] : ov[8]);
            r.busy = r.busy + 8'd1;
            r.hilo = r.hilo + 8'(ov[3]);
            r.done = r.done + 8'(ov[1]);
            r.exc  = r.exc  + 8'(ov[0]);
            if (ov[1]) begin
                r.done_at = 8'(c); r.hilo_at_done = ov[3]; r.exc_at_done = ov[0];
                r.hisel = ov[5:4]; r.dtype = ov[6];
            end
            if (!hold) start_v = 1'b0;
            dz_v = (c == dz_cyc);
        end
        dz_v = 1'b0;
        r.tmo = !ended;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start_v = 1'b0; dz_v = 1'b0; sel = 1'b0; op_v = 2'b00;
        #12;
        tests++; if (o1 !== 9'b0) begin fails++; $display("FAIL reset_dut1: got %b expected %b", o1, 9'b0); end
        tests++; if (o2 !== 9'b0) begin fails++; $display("FAIL reset_dut2: got %b expected %b", o2, 9'b0); end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_op(input string nm, input bit s, input logic [1:0] o, input int dz_cyc, input obs_t e_in);
        obs_t r, e;
        exp_q.push_back(e_in);
        run_op(s, o, dz_cyc, 0, 0, r);
        e = exp_q.pop_front();
        tests++;
        if (r !== e) begin fails++; $display("FAIL %s: got %s | expected %s", nm, fmt(r), fmt(e)); end
    endtask

    task automatic test_reserved;
        logic [8:0] want;
        want = 9'b001000000;   // divm left DIV_type=1, HI/LO selects 0
        sel = 1'b0;
        @(negedge clk); op_v = 2'b11; start_v = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            start_v = 1'b0;
            tests++;
            if (o1 !== want) begin fails++; $display("FAIL reserved_op cyc%0d: got %b expected %b", i, o1, want); end
        end
    endtask

    task automatic test_back_to_back;
        obs_t r, e;
        exp_q.push_back(exp_ok(32, 1, 0));
        exp_q.push_back(exp_ok(32, 1, 0));
        run_op(0, 2'b00, 0, 1, 0, r);   // start stays high across the whole operation
        e = exp_q.pop_front();
        tests++;
        if (r !== e) begin fails++; $display("FAIL held_first: got %s | expected %s", fmt(r), fmt(e)); end
        run_op(0, 2'b00, 0, 0, 1, r);   // held start must be taken in the single idle cycle
        e = exp_q.pop_front();
        tests++;
        if (r !== e) begin fails++; $display("FAIL held_second: got %s | expected %s", fmt(r), fmt(e)); end
    endtask

    task automatic test_reset_mid;
        int   bad = 0;
        obs_t r, e;
        sel = 1'b0;
        @(negedge clk); op_v = 2'b00; start_v = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            start_v = 1'b0;
            if (o1[3] || o1[1] || o1[0]) bad++;
        end
        #2 rst_n = 1'b0;
        #1;
        tests++; if (o1 !== 9'b0) begin fails++; $display("FAIL reset_mid_outputs: got %b expected %b", o1, 9'b0); end
        repeat (2) begin
            @(negedge clk);
            if (o1[3] || o1[1] || o1[0]) bad++;
        end
        tests++; if (bad !== 0) begin fails++; $display("FAIL reset_mid_strobes: got %0d expected 0", bad); end
        rst_n = 1'b1;
        exp_q.push_back(exp_ok(32, 1, 0));
        run_op(0, 2'b00, 0, 0, 0, r);
        e = exp_q.pop_front();
        tests++;
        if (r !== e) begin fails++; $display("FAIL reset_mid_rerun: got %s | expected %s", fmt(r), fmt(e)); end
    endtask

    initial begin
        test_reset;
        test_op("mult",       0, 2'b00, 0, exp_ok(32, 1, 0));
        test_op("div",        0, 2'b01, 0, exp_ok(32, 0, 0));
        test_op("divm",       0, 2'b10, 0, exp_ok(32, 0, 1));
        test_reserved;
        test_op("div0",       0, 2'b01, 3, exp_abort(3, 0));
        test_op("divm0_c1",   0, 2'b10, 1, exp_abort(1, 1));
        test_back_to_back;
        test_op("mult_dz",    0, 2'b00, 5, exp_ok(32, 1, 0));
        test_reset_mid;
        test_op("p_mult1",    1, 2'b00, 0, exp_ok(1, 1, 0));
        test_op("p_div4",     1, 2'b01, 0, exp_ok(4, 0, 0));
        test_op("p_div0last", 1, 2'b01, 4, exp_abort(4, 0));
        test_op("p_mult1b",   1, 2'b00, 0, exp_ok(1, 1, 0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
